// File: rtl/timer_pkg.sv
// Shared definitions for the timer scheduler: FSM state encoding and
// default sizing parameters.
package timer_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 13;
  localparam int DEF_IDX_WIDTH  = 2;

  // 2-bit state encoding; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit found
// scanning upward from ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import timer_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 valid,
  output logic [IDX_WIDTH-1:0] idx
);

  // Scan from the farthest position back toward ptr so the nearest set bit
  // is the last one written and therefore wins.
  always_comb begin
    int pos;
    logic [IDX_WIDTH-1:0] sel;
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      sel = IDX_WIDTH'(pos);
      if (req[sel]) begin
        valid = 1'b1;
        idx   = sel;
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// One shared down-counter serving NUM_REQ requesters round-robin. The
// winner's delay is latched at accept, counted down to zero, and the
// requester then gets a single-cycle done pulse. Dropping the request
// while counting aborts the service without a done pulse.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                          clock_in,
  input  logic                          reset_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] delay_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [NUM_REQ-1:0]            done_out,
  output logic                          busy_out
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] counter_q, counter_d;
  logic [IDX_WIDTH-1:0]  owner_q, owner_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;

  logic                  arb_valid;
  logic [IDX_WIDTH-1:0]  arb_idx;
  logic [IDX_WIDTH-1:0]  next_ptr;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_arb (
    .req   (req_in),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // After a service (completed or aborted) the owner drops to lowest priority.
  assign next_ptr = (owner_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                         : owner_q + IDX_WIDTH'(1);

  // State, counter, owner and pointer registers; async reset drops the grant at once.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
    end
  end

  // Next-state logic: accept in IDLE, count or abort in COUNT, advance pointer in DONE.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d   = arb_idx;
          counter_d = delay_in[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          state_d   = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // Abort wins over reaching zero.
        if (!req_in[owner_q]) begin
          state_d = ST_IDLE;
          ptr_d   = next_ptr;
        end else if (counter_q == '0) begin
          state_d = ST_DONE;
        end else begin
          counter_d = counter_q - DATA_WIDTH'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = next_ptr;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_out = (state_q != ST_IDLE);

  // Per-requester grant/done decode straight from the state register.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_decode
    assign grant_out[gi] = busy_out && (owner_q == IDX_WIDTH'(gi));
    assign done_out[gi]  = (state_q == ST_DONE) && (owner_q == IDX_WIDTH'(gi));
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed testbench for timer_scheduler (NUM_REQ=4, DATA_WIDTH=13).
module tb_timer_scheduler;

  localparam int N  = 4;
  localparam int DW = 13;

  logic            clock_in;
  logic            reset_in;
  logic [N-1:0]    req_in;
  logic [N*DW-1:0] delay_in;
  logic [N-1:0]    grant_out;
  logic [N-1:0]    done_out;
  logic            busy_out;

  int checks;
  int errors;

  timer_scheduler #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .IDX_WIDTH  (2)
  ) dut (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .req_in    (req_in),
    .delay_in  (delay_in),
    .grant_out (grant_out),
    .done_out  (done_out),
    .busy_out  (busy_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic set_delay(input int i, input int val);
    delay_in[i*DW +: DW] = DW'(val);
  endtask

  // Short pulse of the async reset between clock edges.
  task automatic do_reset();
    reset_in = 1'b1;
    #2;
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    req_in   = '0;
    delay_in = '0;
    #3;
    checks++;
    if ({grant_out, done_out, busy_out} !== 9'b0) begin
      errors++;
      $display("FAIL reset_async: got g=%b d=%b b=%b expected all 0", grant_out, done_out, busy_out);
    end
    tick();
    tick();
    reset_in = 1'b0;
    tick();
    checks++;
    if ({grant_out, done_out, busy_out} !== 9'b0) begin
      errors++;
      $display("FAIL reset_idle: got g=%b d=%b b=%b expected all 0", grant_out, done_out, busy_out);
    end
    $display("test_reset: done");
  endtask

  // Requester 0, D=5: grant for 7 cycles, done only in the 7th.
  task automatic test_single();
    logic [N-1:0] eg, ed;
    logic eb;
    set_delay(0, 5);
    req_in = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      eg = (k <= 7) ? 4'b0001 : 4'b0000;
      ed = (k == 7) ? 4'b0001 : 4'b0000;
      eb = (k <= 7);
      checks++;
      if ({grant_out, done_out, busy_out} !== {eg, ed, eb}) begin
        errors++;
        $display("FAIL single_d5 cycle %0d: got g=%b d=%b b=%b expected g=%b d=%b b=%b",
                 k, grant_out, done_out, busy_out, eg, ed, eb);
      end
      if (k == 7) req_in = '0;
    end
    $display("test_single: req0 delay 5 serviced");
  endtask

  // All four requesting with zero delay: strict rotation with an IDLE gap.
  task automatic test_round_robin();
    logic [N-1:0] order [5];
    logic [N-1:0] g;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    delay_in = '0;
    req_in   = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      g = order[s];
      tick();
      checks++;
      if ({grant_out, done_out, busy_out} !== {g, 4'b0000, 1'b1}) begin
        errors++;
        $display("FAIL rr_count svc %0d: got g=%b d=%b b=%b expected g=%b d=0000 b=1",
                 s, grant_out, done_out, busy_out, g);
      end
      tick();
      checks++;
      if ({grant_out, done_out, busy_out} !== {g, g, 1'b1}) begin
        errors++;
        $display("FAIL rr_done svc %0d: got g=%b d=%b b=%b expected g=%b d=%b b=1",
                 s, grant_out, done_out, busy_out, g, g);
      end
      tick();
      checks++;
      if ({grant_out, done_out, busy_out} !== 9'b0) begin
        errors++;
        $display("FAIL rr_idle svc %0d: got g=%b d=%b b=%b expected all 0",
                 s, grant_out, done_out, busy_out);
      end
      $display("test_round_robin: service %0d grant %b", s, g);
    end
    req_in = '0;
    tick();
  endtask

  // D=0: done pulse in the second cycle after accept.
  task automatic test_zero_delay();
    logic [N-1:0] eg, ed;
    logic eb;
    do_reset();
    set_delay(2, 0);
    req_in = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      tick();
      eg = (k <= 2) ? 4'b0100 : 4'b0000;
      ed = (k == 2) ? 4'b0100 : 4'b0000;
      eb = (k <= 2);
      checks++;
      if ({grant_out, done_out, busy_out} !== {eg, ed, eb}) begin
        errors++;
        $display("FAIL zero_delay cycle %0d: got g=%b d=%b b=%b expected g=%b d=%b b=%b",
                 k, grant_out, done_out, busy_out, eg, ed, eb);
      end
      if (k == 2) req_in = '0;
    end
    $display("test_zero_delay: req2 delay 0 serviced");
  endtask

  // Owner 2 aborts in its 3rd COUNT cycle; requester 3 follows after one IDLE.
  task automatic test_abort();
    logic [N-1:0] eg, ed;
    logic eb;
    do_reset();
    set_delay(2, 20);
    set_delay(3, 1);
    req_in = 4'b1100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      eg = (k <= 3) ? 4'b0100 : (k >= 5 && k <= 7) ? 4'b1000 : 4'b0000;
      ed = (k == 7) ? 4'b1000 : 4'b0000;
      eb = (k != 4) && (k != 8);
      checks++;
      if ({grant_out, done_out, busy_out} !== {eg, ed, eb}) begin
        errors++;
        $display("FAIL abort cycle %0d: got g=%b d=%b b=%b expected g=%b d=%b b=%b",
                 k, grant_out, done_out, busy_out, eg, ed, eb);
      end
      if (k == 3) req_in = 4'b1000;
      if (k == 7) req_in = '0;
    end
    $display("test_abort: req2 aborted, req3 serviced");
  endtask

  // Reset during a long count clears outputs without a clock; pointer back to 0.
  task automatic test_reset_mid_count();
    do_reset();
    set_delay(0, 0);
    req_in = 4'b0001;
    tick();
    tick();
    req_in = '0;
    tick();
    set_delay(1, 100);
    req_in = 4'b0010;
    for (int k = 1; k <= 4; k++) tick();
    checks++;
    if ({grant_out, busy_out} !== {4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_grant: got g=%b b=%b expected g=0010 b=1", grant_out, busy_out);
    end
    #2;
    reset_in = 1'b1;
    #1;
    checks++;
    if ({grant_out, done_out, busy_out} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got g=%b d=%b b=%b expected all 0", grant_out, done_out, busy_out);
    end
    tick();
    reset_in = 1'b0;
    set_delay(0, 3);
    req_in = 4'b0011;
    tick();
    checks++;
    if ({grant_out, done_out, busy_out} !== {4'b0001, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_ptr: got g=%b d=%b b=%b expected g=0001 d=0000 b=1",
               grant_out, done_out, busy_out);
    end
    req_in = '0;
    tick();
    $display("test_reset_mid_count: reset dropped grant, req0 won after release");
  endtask

  // Delay changed mid-count must not affect the latched value.
  task automatic test_latched_delay();
    logic [N-1:0] eg, ed;
    logic eb;
    do_reset();
    set_delay(0, 10);
    req_in = 4'b0001;
    for (int k = 1; k <= 13; k++) begin
      tick();
      eg = (k <= 12) ? 4'b0001 : 4'b0000;
      ed = (k == 12) ? 4'b0001 : 4'b0000;
      eb = (k <= 12);
      checks++;
      if ({grant_out, done_out, busy_out} !== {eg, ed, eb}) begin
        errors++;
        $display("FAIL latched_delay cycle %0d: got g=%b d=%b b=%b expected g=%b d=%b b=%b",
                 k, grant_out, done_out, busy_out, eg, ed, eb);
      end
      if (k == 3) set_delay(0, 2);
      if (k == 12) req_in = '0;
    end
    $display("test_latched_delay: req0 delay 10 held despite change to 2");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_delay();
    test_abort();
    test_reset_mid_count();
    test_latched_delay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
